instr_fetch: RTL and testbench

Instruction fetch unit for the 8-bit microprocessor. It reads the program counter value from the PR register and issues byte reads to program memory through a req/ack handshake. It assembles 1- or 2-byte instructions and presents them to the decode/execute stage through a valid/ready handshake. It also drives the PR control inputs: a single-cycle `increment_pr` pulse per fetched byte, and `ar_on_pr` with `data_2_pr` to load a branch target.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 30 +++
 rtl/fetch_branch_latch.sv | 29 ++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and instruction-format constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH_OP,
    INC_OP,
    FETCH_ARG,
    INC_ARG,
    HOLD,
    BRANCH
  } fetch_state_t;

  localparam int         OPC_TWO_BYTE_BIT = 7;
  localparam logic [7:0] RESET_PC         = 8'h00;

  function automatic logic is_two_byte(input logic [7:0] opcode);
    return opcode[OPC_TWO_BYTE_BIT];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: PR control, program-memory read handshake, instruction handshake, redirect.
interface instr_fetch_if #(parameter int MEM_AW = 8);
  logic [MEM_AW-1:0] pc_in;
  logic              increment_pr;
  logic              ar_on_pr;
  logic [MEM_AW-1:0] data_2_pr;
  logic              mem_rd_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_ack;
  logic [7:0]        mem_rd_data;
  logic              ir_valid;
  logic              ir_ready;
  logic [7:0]        ir_opcode;
  logic [7:0]        ir_operand;
  logic [MEM_AW-1:0] ir_pc;
  logic              branch_req;
  logic [MEM_AW-1:0] branch_target;

  modport master (
    input  pc_in, mem_rd_ack, mem_rd_data, ir_ready, branch_req, branch_target,
    output increment_pr, ar_on_pr, data_2_pr, mem_rd_req, mem_addr,
           ir_valid, ir_opcode, ir_operand, ir_pc
  );

  modport slave (
    output pc_in, mem_rd_ack, mem_rd_data, ir_ready, branch_req, branch_target,
    input  increment_pr, ar_on_pr, data_2_pr, mem_rd_req, mem_addr,
           ir_valid, ir_opcode, ir_operand, ir_pc
  );
endinterface

// File: rtl/fetch_branch_latch.sv
// Pending-branch holder: a request sets it (newest target wins), taking the branch clears it.
module fetch_branch_latch #(parameter int AW = 8) (
  input  logic          clk,
  input  logic          rst,
  input  logic          branch_req,
  input  logic [AW-1:0] branch_target,
  input  logic          take,
  output logic          pend_any,
  output logic [AW-1:0] pend_target
);
  logic          pend;
  logic [AW-1:0] pend_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else if (take) begin
      pend     <= 1'b0;
    end else if (branch_req) begin
      pend     <= 1'b1;
      pend_tgt <= branch_target;
    end
  end

  // A request arriving in the resolving cycle is forwarded so it is neither lost nor left pending.
  assign pend_any    = pend | branch_req;
  assign pend_target = branch_req ? branch_target : pend_tgt;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads 1- or 2-byte instructions via PR/memory and hands them to decode.
module instr_fetch import cpu_pkg::*; #(parameter int MEM_AW = 8) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  // state        | meaning
  // FETCH_OP/ARG | read opcode/operand byte at pc_in;  INC_OP/ARG | pulse increment_pr
  // HOLD         | present instruction to decode;     BRANCH     | load PR with pending target
  fetch_state_t      state, state_nxt;
  logic              take, ack, pend_any;
  logic [MEM_AW-1:0] pend_target;

  logic              mem_rd_req_q, increment_pr_q, ar_on_pr_q, ir_valid_q;
  logic [MEM_AW-1:0] data_2_pr_q, ir_pc_q;
  logic [7:0]        ir_opcode_q, ir_operand_q;

  assign ack = mem_rd_req_q & bus.mem_rd_ack;

  fetch_branch_latch #(.AW(MEM_AW)) u_branch (
    .clk           (clk),
    .rst           (rst),
    .branch_req    (bus.branch_req),
    .branch_target (bus.branch_target),
    .take          (take),
    .pend_any      (pend_any),
    .pend_target   (pend_target)
  );

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    unique case (state)
      FETCH_OP, FETCH_ARG: begin
        if (ack) begin
          if (pend_any) begin
            state_nxt = BRANCH;
            take      = 1'b1;
          end else begin
            state_nxt = (state == FETCH_OP) ? INC_OP : INC_ARG;
          end
        end
      end
      INC_OP: begin
        if (pend_any) begin
          state_nxt = BRANCH;
          take      = 1'b1;
        end else begin
          state_nxt = is_two_byte(ir_opcode_q) ? FETCH_ARG : HOLD;
        end
      end
      INC_ARG, HOLD: begin
        if (pend_any) begin
          state_nxt = BRANCH;
          take      = 1'b1;
        end else if (state == INC_ARG) begin
          state_nxt = HOLD;
        end else if (bus.ir_ready) begin
          state_nxt = FETCH_OP;
        end
      end
      BRANCH:  state_nxt = FETCH_OP;
      default: state_nxt = FETCH_OP;
    endcase
  end

  // Outputs are registered from the next state so each one is valid for the whole state cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH_OP;
      mem_rd_req_q   <= 1'b0;
      increment_pr_q <= 1'b0;
      ar_on_pr_q     <= 1'b0;
      data_2_pr_q    <= '0;
      ir_valid_q     <= 1'b0;
      ir_opcode_q    <= '0;
      ir_operand_q   <= '0;
      ir_pc_q        <= MEM_AW'(RESET_PC);
    end else begin
      state          <= state_nxt;
      mem_rd_req_q   <= (state_nxt == FETCH_OP) || (state_nxt == FETCH_ARG);
      increment_pr_q <= (state_nxt == INC_OP) || (state_nxt == INC_ARG);
      ar_on_pr_q     <= (state_nxt == BRANCH);
      data_2_pr_q    <= (state_nxt == BRANCH) ? pend_target : '0;
      ir_valid_q     <= (state_nxt == HOLD);
      if (state == FETCH_OP && state_nxt == INC_OP) begin
        ir_opcode_q  <= bus.mem_rd_data;
        ir_pc_q      <= bus.pc_in;
        ir_operand_q <= '0;
      end
      if (state == FETCH_ARG && state_nxt == INC_ARG)
        ir_operand_q <= bus.mem_rd_data;
    end
  end

  assign bus.mem_rd_req   = mem_rd_req_q;
  assign bus.mem_addr     = mem_rd_req_q ? bus.pc_in : '0;
  assign bus.increment_pr = increment_pr_q;
  assign bus.ar_on_pr     = ar_on_pr_q;
  assign bus.data_2_pr    = data_2_pr_q;
  assign bus.ir_valid     = ir_valid_q;
  assign bus.ir_opcode    = ir_opcode_q;
  assign bus.ir_operand   = ir_operand_q;
  assign bus.ir_pc        = ir_pc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PR and memory models, directed scenarios, then randomized stream.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.MEM_AW(8)) bif();
  instr_fetch #(.MEM_AW(8)) dut (.clk(clk), .rst(rst), .bus(bif));

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mem [256];
  logic [7:0] pc;
  int         wait_cfg = 0;
  int         wcnt = 0;
  int         inc_cnt = 0, ar_cnt = 0, ack_cnt = 0;
  logic       prev_req = 1'b0, prev_ack = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // program register model
  always @(posedge clk) begin
    if (rst)                pc <= 8'h00;
    else if (bif.ar_on_pr)  pc <= bif.data_2_pr;
    else if (bif.increment_pr) pc <= pc + 8'd1;
  end
  assign bif.pc_in = pc;

  // memory with programmable wait states; ack may come in the request cycle
  always @(posedge clk) begin
    if (rst || !bif.mem_rd_req || bif.mem_rd_ack) wcnt <= 0;
    else                                          wcnt <= wcnt + 1;
  end
  assign bif.mem_rd_ack  = bif.mem_rd_req && (wcnt >= wait_cfg);
  assign bif.mem_rd_data = bif.mem_rd_ack ? mem[bif.mem_addr] : 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_req <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      check("excl_inc_ar", 32'(bif.increment_pr & bif.ar_on_pr), 32'd0);
      check("mem_addr_gate", 32'(bif.mem_addr), bif.mem_rd_req ? 32'(pc) : 32'd0);
      if (!bif.ar_on_pr) check("d2pr_idle", 32'(bif.data_2_pr), 32'd0);
      if (prev_req && !prev_ack) begin
        check("req_hold", 32'(bif.mem_rd_req), 32'd1);
        check("addr_hold", 32'(bif.mem_addr), 32'(prev_addr));
      end
      inc_cnt   <= inc_cnt + int'(bif.increment_pr);
      ar_cnt    <= ar_cnt + int'(bif.ar_on_pr);
      ack_cnt   <= ack_cnt + int'(bif.mem_rd_ack);
      prev_req  <= bif.mem_rd_req;
      prev_ack  <= bif.mem_rd_ack;
      prev_addr <= bif.mem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    while (!bif.mem_rd_req && n < max) begin step(); n++; end
    if (!bif.mem_rd_req) check("req_timeout", 32'(bif.mem_rd_req), 32'd1);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bif.ir_valid && n < max) begin step(); n++; end
    if (!bif.ir_valid) check("valid_timeout", 32'(bif.ir_valid), 32'd1);
  endtask

  task automatic wait_ar(input int max, output int n);
    n = 0;
    while (!bif.ar_on_pr && n < max) begin step(); n++; end
    if (!bif.ar_on_pr) check("ar_timeout", 32'(bif.ar_on_pr), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.ir_ready = 1'b0;
    bif.branch_req = 1'b0;
    bif.branch_target = 8'h00;
    step();
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},  32'(bif.mem_rd_req), 32'd0);
    check({tag, "_addr"}, 32'(bif.mem_addr), 32'd0);
    check({tag, "_inc"},  32'(bif.increment_pr), 32'd0);
    check({tag, "_ar"},   32'(bif.ar_on_pr), 32'd0);
    check({tag, "_d2pr"}, 32'(bif.data_2_pr), 32'd0);
    check({tag, "_ir"},   {bif.ir_valid, bif.ir_opcode, bif.ir_operand, bif.ir_pc}, 32'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, lat, inc0, ar0, ack0, delivered, cyc;
    logic [7:0] next_pc, cur_pc, op, opd;
    logic shown, br, rdy;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h12;
    mem[1] = 8'h01;

    // 1-byte fetch, zero-wait
    do_reset();
    check_all_zero("rst");
    rst = 1'b0;
    wait_req(10, n);
    check("t1_addr", 32'(bif.mem_addr), 32'h00);
    inc0 = inc_cnt;
    wait_valid(20, lat);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_inc_pulses", 32'(inc_cnt - inc0), 32'd1);
    check("t1_op", 32'(bif.ir_opcode), 32'h12);
    check("t1_opd", 32'(bif.ir_operand), 32'h00);
    check("t1_pc", 32'(bif.ir_pc), 32'h00);
    bif.ir_ready = 1'b1;
    step();
    bif.ir_ready = 1'b0;
    wait_req(10, n);
    check("t1_next_addr", 32'(bif.mem_addr), 32'h01);

    // 2-byte fetch, two wait cycles per read
    do_reset();
    mem[0] = 8'h85;
    mem[1] = 8'h3C;
    wait_cfg = 2;
    rst = 1'b0;
    wait_req(10, n);
    inc0 = inc_cnt;
    wait_valid(40, lat);
    check("t2_latency", 32'(lat), 32'd8);
    check("t2_inc_pulses", 32'(inc_cnt - inc0), 32'd2);
    check("t2_op", 32'(bif.ir_opcode), 32'h85);
    check("t2_opd", 32'(bif.ir_operand), 32'h3C);
    check("t2_pc", 32'(bif.ir_pc), 32'h00);

    // backpressure
    inc0 = inc_cnt;
    ar0 = ar_cnt;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_valid", 32'(bif.ir_valid), 32'd1);
      check("t3_instr", {8'h00, bif.ir_opcode, bif.ir_operand, bif.ir_pc}, 32'h00853C00);
      check("t3_req", 32'(bif.mem_rd_req), 32'd0);
    end
    check("t3_no_pulse", 32'((inc_cnt - inc0) + (ar_cnt - ar0)), 32'd0);

    // branch from HOLD together with ready
    mem[8'h40] = 8'h07;
    wait_cfg = 3;
    ar0 = ar_cnt;
    bif.branch_req = 1'b1;
    bif.branch_target = 8'h40;
    bif.ir_ready = 1'b1;
    step();
    bif.branch_req = 1'b0;
    bif.ir_ready = 1'b0;
    check("t4_ar", 32'(bif.ar_on_pr), 32'd1);
    check("t4_d2pr", 32'(bif.data_2_pr), 32'h40);
    check("t4_valid_drop", 32'(bif.ir_valid), 32'd0);
    step();
    check("t4_req", 32'(bif.mem_rd_req), 32'd1);
    check("t4_addr", 32'(bif.mem_addr), 32'h40);
    check("t4_ar_pulses", 32'(ar_cnt - ar0), 32'd1);

    // branch while the read at 0x40 is still waiting for ack
    mem[8'h20] = 8'h11;
    inc0 = inc_cnt;
    ack0 = ack_cnt;
    bif.branch_req = 1'b1;
    bif.branch_target = 8'h20;
    step();
    bif.branch_req = 1'b0;
    wait_ar(20, n);
    check("t5_d2pr", 32'(bif.data_2_pr), 32'h20);
    check("t5_no_inc", 32'(inc_cnt - inc0), 32'd0);
    check("t5_acked", 32'(ack_cnt - ack0), 32'd1);
    wait_valid(30, n);
    check("t5_op", 32'(bif.ir_opcode), 32'h11);
    check("t5_pc", 32'(bif.ir_pc), 32'h20);
    check("t5_opd", 32'(bif.ir_operand), 32'h00);

    // flush from HOLD to 0xFF, 2-byte instruction wrapping to 0x00
    mem[8'hFF] = 8'h9A;
    mem[0] = 8'h55;
    wait_cfg = 0;
    bif.branch_req = 1'b1;
    bif.branch_target = 8'hFF;
    step();
    bif.branch_req = 1'b0;
    check("t6_flush", 32'(bif.ir_valid), 32'd0);
    check("t6_d2pr", 32'(bif.data_2_pr), 32'hFF);
    wait_valid(30, n);
    check("t6_instr", {8'h00, bif.ir_opcode, bif.ir_operand, bif.ir_pc}, 32'h009A55FF);
    bif.ir_ready = 1'b1;
    step();
    bif.ir_ready = 1'b0;
    wait_req(10, n);
    check("t6_next_addr", 32'(bif.mem_addr), 32'h01);

    // reset while a read is outstanding
    wait_cfg = 3;
    step();
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    wait_req(10, n);
    check("midrst_addr", 32'(bif.mem_addr), 32'h00);

    // randomized stream against an instruction-level model
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b0;
    next_pc = 8'h00;
    shown = 1'b0;
    delivered = 0;
    cyc = 0;
    while (delivered < 200 && cyc < 20000) begin
      if (bif.ir_valid && !shown) begin
        cur_pc = next_pc;
        op = mem[cur_pc];
        opd = op[7] ? mem[8'(cur_pc + 8'd1)] : 8'h00;
        check("rnd_op", 32'(bif.ir_opcode), 32'(op));
        check("rnd_opd", 32'(bif.ir_operand), 32'(opd));
        check("rnd_pc", 32'(bif.ir_pc), 32'(cur_pc));
        next_pc = cur_pc + (op[7] ? 8'd2 : 8'd1);
        shown = 1'b1;
        delivered++;
      end
      br = ($urandom_range(0, 11) == 0);
      rdy = 1'($urandom_range(0, 1));
      bif.branch_req = br;
      bif.branch_target = 8'($urandom);
      bif.ir_ready = rdy;
      wait_cfg = $urandom_range(0, 2);
      if (br) next_pc = bif.branch_target;
      if (bif.ir_valid && (br || rdy)) shown = 1'b0;
      step();
      cyc++;
    end
    check("rnd_progress", 32'(delivered >= 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
